// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver: shadow-registered display data,
// per-digit refresh timing, leading-zero suppression and registered pin outputs.
module ssd_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW_SEG}};
    localparam logic                  DP_OFF   = ACTIVE_LOW_SEG;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW_AN}};

    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        case (nib)
            4'h0: seg7_encode = 7'h3F;
            4'h1: seg7_encode = 7'h06;
            4'h2: seg7_encode = 7'h5B;
            4'h3: seg7_encode = 7'h4F;
            4'h4: seg7_encode = 7'h66;
            4'h5: seg7_encode = 7'h6D;
            4'h6: seg7_encode = 7'h7D;
            4'h7: seg7_encode = 7'h07;
            4'h8: seg7_encode = 7'h7F;
            4'h9: seg7_encode = 7'h6F;
            4'hA: seg7_encode = 7'h77;
            4'hB: seg7_encode = 7'h7C;
            4'hC: seg7_encode = 7'h58;
            4'hD: seg7_encode = 7'h5E;
            4'hE: seg7_encode = 7'h79;
            default: seg7_encode = 7'h71;
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic [NUM_DIGITS-1:0]   bm_q, bm_d;
    logic                    lz_q, lz_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    fd_q, fd_d;

    logic                    terminal;
    logic                    seen;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              nib;
    logic                    sel_blank;
    logic                    sel_dp;

    always_comb begin
        terminal  = (cnt_q == CNT_LAST);
        cnt_d     = terminal ? '0 : cnt_q + 1'b1;
        idx_d     = idx_q;
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        fd_d      = terminal && (idx_q == IDX_LAST);

        val_d     = load ? value       : val_q;
        dpm_d     = load ? dp_in       : dpm_q;
        bm_d      = load ? blank_mask  : bm_q;
        lz_d      = load ? lz_suppress : lz_q;

        // Walk down from the top digit; a digit stays dark until a non-zero nibble is seen.
        seen      = 1'b0;
        lz_blank  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (val_q[4*i +: 4] != 4'h0) seen = 1'b1;
            lz_blank[i] = lz_q & ~seen;
        end

        nib       = 4'h0;
        onehot    = '0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib       = val_q[4*i +: 4];
                onehot[i] = 1'b1;
                sel_blank = bm_q[i] | lz_blank[i];
                sel_dp    = dpm_q[i];
            end
        end

        seg_d = sel_blank ? SEG_OFF : (seg7_encode(nib) ^ SEG_OFF);
        dp_d  = (~sel_blank & sel_dp) ^ DP_OFF;
        an_d  = sel_blank ? AN_OFF : (onehot ^ AN_OFF);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dpm_q <= '0;
            bm_q  <= '0;
            lz_q  <= 1'b0;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
            fd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dpm_q <= dpm_d;
            bm_q  <= bm_d;
            lz_q  <= lz_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
            fd_q  <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed scenarios plus randomized traffic, compared every
// clock against an edge-count based reference of the display schedule.
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        lz_suppress = 1'b0;
    logic        load = 1'b0;

    logic [6:0]  seg, seg_l;
    logic        dp, dp_l;
    logic [3:0]  an, an_l;
    logic        fd, fd_l;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: shadow contents and number of scan edges since reset.
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp  = 4'h0;
    logic [3:0]  m_bm  = 4'h0;
    logic        m_lz  = 1'b0;
    int          k     = 0;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

    ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW_SEG(1'b0), .ACTIVE_LOW_AN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
        .lz_suppress(lz_suppress), .load(load), .seg(seg), .dp(dp), .an(an), .frame_done(fd)
    );

    ssd_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
        .lz_suppress(lz_suppress), .load(load), .seg(seg_l), .dp(dp_l), .an(an_l), .frame_done(fd_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic ld);
        int         d;
        logic       blank;
        logic [3:0] nib;
        logic [6:0] es;
        logic       edp;
        logic [3:0] ean;
        logic       efd;
        @(negedge clk);
        rst_n = r;
        load  = ld;
        if (!r) begin
            es = 7'h00; edp = 1'b0; ean = 4'hF; efd = 1'b0;
            k = 0; m_val = 16'h0; m_dp = 4'h0; m_bm = 4'h0; m_lz = 1'b0;
        end else begin
            d     = (k / RD) % ND;
            nib   = 4'(m_val >> (4 * d));
            blank = m_bm[d] || (m_lz && d > 0 && (m_val >> (4 * d)) == 16'h0);
            es    = blank ? 7'h00 : segtab[nib];
            edp   = !blank && m_dp[d];
            ean   = blank ? 4'hF : ~(4'b0001 << d);
            efd   = (k % (RD * ND)) == (RD * ND - 1);
            k++;
            if (ld) begin
                m_val = value; m_dp = dp_in; m_bm = blank_mask; m_lz = lz_suppress;
            end
        end
        @(posedge clk);
        #1;
        check("seg",           32'(seg),  32'(es));
        check("dp",            32'(dp),   32'(edp));
        check("an",            32'(an),   32'(ean));
        check("frame_done",    32'(fd),   32'(efd));
        check("seg_activelow", 32'(seg_l), 32'(es ^ 7'h7F));
        check("dp_activelow",  32'(dp_l),  32'(!edp));
        check("an_activelow",  32'(an_l),  32'(ean));
        check("fd_activelow",  32'(fd_l),  32'(efd));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0);
    endtask

    task automatic set_in(input logic [15:0] v, input logic [3:0] dpi, input logic [3:0] bm, input logic lz);
        value = v; dp_in = dpi; blank_mask = bm; lz_suppress = lz;
    endtask

    initial begin
        logic [15:0] v;
        // Reset: both polarities of the segment pins
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        // Plain hex scan of 12AF, frame pulse every 16 clocks
        set_in(16'h12AF, 4'h0, 4'h0, 1'b0);
        tick(1'b1, 1'b1);
        run(40);

        // Leading-zero suppression, then all-zero value
        set_in(16'h0005, 4'h0, 4'h0, 1'b1);
        tick(1'b1, 1'b1);
        run(20);
        set_in(16'h0000, 4'h0, 4'h0, 1'b1);
        tick(1'b1, 1'b1);
        run(16);
        set_in(16'h0300, 4'h0, 4'h0, 1'b1);
        tick(1'b1, 1'b1);
        run(16);

        // Decimal point and blank mask
        set_in(16'h8765, 4'b0100, 4'b1000, 1'b0);
        tick(1'b1, 1'b1);
        run(20);

        // Inputs change without load: display holds
        set_in(16'h4321, 4'b1111, 4'b0000, 1'b1);
        run(20);

        // Load coinciding with terminal count
        while ((k % RD) != RD - 1) tick(1'b1, 1'b0);
        set_in(16'hBCDE, 4'b0010, 4'b0000, 1'b0);
        tick(1'b1, 1'b1);
        run(20);

        // All eights: active-low segment instance shows all pins low
        set_in(16'h8888, 4'b1111, 4'b0000, 1'b0);
        tick(1'b1, 1'b1);
        run(16);

        // Reset mid-scan of digit 2, with a coincident load that must be ignored
        while (!(((k / RD) % ND) == 2 && (k % RD) == 1)) tick(1'b1, 1'b0);
        set_in(16'hFFFF, 4'hF, 4'h0, 1'b0);
        tick(1'b0, 1'b1);
        run(20);
        set_in(16'h9A0C, 4'b0001, 4'b0000, 1'b0);
        tick(1'b1, 1'b1);
        run(20);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            v = 16'h0;
            for (int i = 0; i < 4; i++) begin
                v[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            set_in(v, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0,
                   1'($urandom_range(0, 1)));
            tick(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
